// File: rtl/data_mem_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : data_mem_if                                                 |
// | Brief   : Core-to-data-memory request/ready bus                       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface data_mem_if;
   logic [31:0] data_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] write_data;
   logic [31:0] data;
   logic        mem_ready;
   logic        addr_error;

   modport master (
      output data_address, mem_read, mem_write, write_data,
      input  data, mem_ready, addr_error
   );

   modport slave (
      input  data_address, mem_read, mem_write, write_data,
      output data, mem_ready, addr_error
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : data_mem_responder                                          |
// | Brief   : Word RAM behind a multi-cycle request/ready handshake with  |
// |           WAIT_STATES wait cycles. Define DMEM_ERR_CHECK_EN to fault  |
// |           misaligned or out-of-range addresses.                       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input  wire logic   clk,
   input  wire logic   reset,
   data_mem_if.slave   bus
);
   localparam int         DEPTH       = 2 ** ADDR_WIDTH;
   localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        is_wr_q, is_wr_d;
   logic [31:0] data_q, data_d;

   logic [31:0] mem [DEPTH];

   logic                  w_req;
   logic [31:0]           w_cur_addr;
   logic                  w_cur_wr;
   logic [ADDR_WIDTH-1:0] w_cur_idx;
   logic                  w_fault;

   assign w_req = bus.mem_read | bus.mem_write;

   // In IDLE the live inputs are the transaction (zero-wait reads enter RESP
   // on the capture edge); afterwards only the latched copies count.
   assign w_cur_addr = (state_q == S_IDLE) ? bus.data_address : addr_q;
   assign w_cur_wr   = (state_q == S_IDLE) ? bus.mem_write    : is_wr_q;
   assign w_cur_idx  = w_cur_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
   assign w_fault = (w_cur_addr[1:0] != 2'b00) || (w_cur_addr[31:ADDR_WIDTH+2] != '0);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{w_cur_addr[1:0], w_cur_addr[31:ADDR_WIDTH+2]};
   assign w_fault          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               addr_d  = bus.data_address;
               wdata_d = bus.write_data;
               is_wr_d = bus.mem_write;
               cnt_d   = C_WAIT_LOAD;
               state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Read data is registered on the edge entering RESP; writes leave it alone.
      if ((state_d == S_RESP) && (state_q != S_RESP) && !w_cur_wr) begin
         data_d = w_fault ? 32'h0000_0000 : mem[w_cur_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         is_wr_q <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         data_q  <= data_d;
      end
   end

   // Commit on the edge leaving RESP; reset forces IDLE, discarding the write.
   always_ff @(posedge clk) begin
      if ((state_q == S_RESP) && is_wr_q && !w_fault) begin
         mem[w_cur_idx] <= wdata_q;
      end
   end

   assign bus.data       = data_q;
   assign bus.mem_ready  = (state_q == S_RESP);
   assign bus.addr_error = (state_q == S_RESP) && w_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_data_mem_responder                                       |
// | Brief   : Scoreboard bench; instance A has 2 wait states, B has 0     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

`ifdef DMEM_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   data_mem_if bus_a ();
   data_mem_if bus_b ();

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model[int];
   logic [31:0] last_data[2];
   int          n_vec  = 0;
   int          n_miss = 0;

   function automatic logic exp_fault(input logic [31:0] a);
      return ERR_EN && ((a[1:0] != 2'b00) || (a[31:12] != 20'h0));
   endfunction

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? bus_a.mem_ready : bus_b.mem_ready;
   endfunction
   function automatic logic [31:0] get_data(input int sel);
      return (sel == 0) ? bus_a.data : bus_b.data;
   endfunction
   function automatic logic get_err(input int sel);
      return (sel == 0) ? bus_a.addr_error : bus_b.addr_error;
   endfunction

   task automatic set_bus(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd);
      if (sel == 0) begin
         bus_a.mem_read = rd; bus_a.mem_write = wr;
         bus_a.data_address = a; bus_a.write_data = wd;
      end else begin
         bus_b.mem_read = rd; bus_b.mem_write = wr;
         bus_b.data_address = a; bus_b.write_data = wd;
      end
   endtask

   // One complete transaction: expectation queued at drive time, popped at ready.
   task automatic txn(input int sel, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, output time t_ready);
      exp_t e;
      int   key;
      int   cyc;
      int   ws;
      logic f;
      ws  = (sel == 0) ? 2 : 0;
      key = sel * 1024 + int'(a[11:2]);
      f   = exp_fault(a);
      e.err = f;
      if (wr)     e.data = last_data[sel];
      else if (f) e.data = 32'h0;
      else        e.data = model[key];
      sb_q.push_back(e);
      if (wr && !f) model[key] = wd;
      if (!wr) last_data[sel] = e.data;
      set_bus(sel, rd, wr, a, wd);
      cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (!get_ready(sel) && cyc < 40);
      t_ready = $time;
      e = sb_q.pop_front();
      n_vec++;
      if (get_ready(sel) !== 1'b1) begin
         n_miss++;
         $display("FAIL timeout dut%0d addr=%h: mem_ready never rose in %0d cycles", sel, a, cyc);
      end else begin
         n_vec++;
         if (cyc != ws + 1) begin
            n_miss++;
            $display("FAIL latency dut%0d addr=%h: got %0d cycles, want %0d", sel, a, cyc, ws + 1);
         end
         n_vec++;
         if (get_data(sel) !== e.data) begin
            n_miss++;
            $display("FAIL data dut%0d addr=%h: got %h, want %h", sel, a, get_data(sel), e.data);
         end
         n_vec++;
         if (get_err(sel) !== e.err) begin
            n_miss++;
            $display("FAIL addr_error dut%0d addr=%h: got %b, want %b", sel, a, get_err(sel), e.err);
         end
      end
      @(posedge clk); #1;
      n_vec++;
      if (get_ready(sel) !== 1'b0) begin
         n_miss++;
         $display("FAIL ready_pulse dut%0d addr=%h: mem_ready=%b one cycle later, want 0", sel, a, get_ready(sel));
      end
      set_bus(sel, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      last_data[0] = 32'h0;
      last_data[1] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         n_vec++;
         if (get_ready(s) !== 1'b0 || get_data(s) !== 32'h0 || get_err(s) !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state dut%0d: ready=%b data=%h err=%b, want 0/00000000/0",
                     s, get_ready(s), get_data(s), get_err(s));
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_abort;
      time t;
      txn(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, t);
      txn(0, 1'b1, 1'b0, 32'h10, 32'h0, t);
      set_bus(0, 1'b0, 1'b1, 32'h10, 32'h9999_9999);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      n_vec++;
      if (bus_a.mem_ready !== 1'b0 || bus_a.data !== 32'h0) begin
         n_miss++;
         $display("FAIL abort_reset: ready=%b data=%h, want 0/00000000", bus_a.mem_ready, bus_a.data);
      end
      set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      last_data[0] = 32'h0;
      last_data[1] = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      txn(0, 1'b1, 1'b0, 32'h10, 32'h0, t);
   endtask

   task automatic test_wait_states;
      time t;
      txn(0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, t);
      txn(0, 1'b1, 1'b0, 32'h40, 32'h0, t);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         a = {22'h0, 8'(8'h80 + $urandom_range(0, 120)), 2'b00};
         d = $urandom;
         txn(0, 1'b0, 1'b1, a, d, t);
         txn(0, 1'b1, 1'b0, a, 32'h0, t);
      end
   endtask

   task automatic test_back_to_back;
      time t_prev;
      time t_now;
      t_prev = 0;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 2; k++) begin
            txn(1, k == 1, k == 0, 32'(i * 4), 32'hB000_0000 + 32'(i), t_now);
            if (i != 0 || k != 0) begin
               n_vec++;
               if (t_now - t_prev != 20) begin
                  n_miss++;
                  $display("FAIL b2b_spacing i=%0d: got %0t between readies, want 20", i, t_now - t_prev);
               end
            end
            t_prev = t_now;
         end
      end
   endtask

   task automatic test_rd_wr_both;
      time t;
      txn(0, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, t);
      txn(0, 1'b1, 1'b0, 32'h20, 32'h0, t);
   endtask

`ifdef DMEM_ERR_CHECK_EN
   task automatic test_addr_error;
      time t;
      txn(0, 1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, t);
      txn(0, 1'b1, 1'b0, 32'h0, 32'h0, t);
      txn(0, 1'b1, 1'b0, 32'h13, 32'h0, t);
      txn(0, 1'b0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, t);
      txn(0, 1'b1, 1'b0, 32'h0, 32'h0, t);
   endtask
`else
   task automatic test_alias;
      time t;
      txn(0, 1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, t);
      txn(0, 1'b1, 1'b0, 32'h0, 32'h0, t);
   endtask
`endif

   initial begin
      test_reset();
      test_abort();
      test_wait_states();
      test_back_to_back();
      test_rd_wr_both();
`ifdef DMEM_ERR_CHECK_EN
      test_addr_error();
`else
      test_alias();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
